// File: rtl/pipe_ctrl_chain.sv
// Parametrised control-word pipeline: DEPTH stages of WIDTH bits with per-stage valid, stall and flush.
// Optional performance counters (bubble_cnt, flush_cnt) are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_chain #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_word,
  input  logic [DEPTH-1:0]         stall,
  input  logic [DEPTH-1:0]         flush,
  output logic [DEPTH-1:0]         out_valid,
  output logic [DEPTH*WIDTH-1:0]   out_word
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [15:0]              bubble_cnt,
  output logic [15:0]              flush_cnt
`endif
);

  localparam int unsigned DW = DEPTH * WIDTH;

  logic [DEPTH-1:0] hold;
  logic [DEPTH-1:0] hold_up;
  logic [DEPTH-1:0] src_valid;
  logic [DW-1:0]    src_word;
  logic [DEPTH-1:0] valid_nxt;
  logic [DW-1:0]    word_nxt;

  // Effective hold propagates from any stalled later stage back toward stage 0
  always_comb begin
    hold = '0;
    hold[DEPTH-1] = stall[DEPTH-1];
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      hold[k] = stall[k] | hold[k + 1];
    end
  end

  // hold_up[k] is the hold of the stage feeding k; stage 0 is never fed by a held stage
  assign hold_up   = hold << 1;
  assign src_valid = (out_valid << 1) | DEPTH'(in_valid);
  assign src_word  = (out_word << WIDTH) | DW'(in_valid ? in_word : '0);

  // Per-stage priority: flush, hold, boundary bubble, advance
  always_comb begin
    valid_nxt = out_valid;
    word_nxt  = out_word;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (flush[k] || (!hold[k] && hold_up[k])) begin
        valid_nxt[k]                = 1'b0;
        word_nxt[k*WIDTH +: WIDTH]  = '0;
      end else if (!hold[k]) begin
        valid_nxt[k]                = src_valid[k];
        word_nxt[k*WIDTH +: WIDTH]  = src_word[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= '0;
      out_word  <= '0;
    end else begin
      out_valid <= valid_nxt;
      out_word  <= word_nxt;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic bubble_c;
  logic flush_hit_c;

  // h is monotonic, so at most one boundary exists per cycle
  assign bubble_c    = |(~flush & ~hold & hold_up);
  assign flush_hit_c = |(flush & out_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (bubble_c && (bubble_cnt != 16'hFFFF)) bubble_cnt <= bubble_cnt + 16'd1;
      if (flush_hit_c && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Self-checking bench for pipe_ctrl_chain: directed cases plus random traffic against a stage-array model.
// Counter checks are included when PIPE_CTRL_PERF_EN is defined.
module tb_pipe_ctrl_chain;

  localparam int unsigned W  = 12;
  localparam int unsigned D  = 3;
  localparam int unsigned DW = W * D;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic [W-1:0]   in_word;
  logic [D-1:0]   stall;
  logic [D-1:0]   flush;
  logic [D-1:0]   out_valid;
  logic [DW-1:0]  out_word;
`ifdef PIPE_CTRL_PERF_EN
  logic [15:0]    bubble_cnt;
  logic [15:0]    flush_cnt;
`endif

  pipe_ctrl_chain #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_word   (in_word),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .out_word  (out_word)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .bubble_cnt(bubble_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: one valid bit and one word per stage, plus event counters
  logic         mv [D];
  logic [W-1:0] mw [D];
  int unsigned  mb;
  int unsigned  mf;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < int'(D); k++) begin
      mv[k] = 1'b0;
      mw[k] = '0;
    end
    mb = 0;
    mf = 0;
  endtask

  task automatic model_step(input logic v, input logic [W-1:0] w,
                            input logic [D-1:0] st, input logic [D-1:0] fl);
    logic         nv [D];
    logic [W-1:0] nw [D];
    bit bub;
    bit fhit;
    bub  = 0;
    fhit = 0;
    for (int k = 0; k < int'(D); k++) begin
      bit held;
      bit up_held;
      held    = ((st >> k) != '0);
      up_held = (k > 0) && ((st >> (k - 1)) != '0);
      if (fl[k] && mv[k]) fhit = 1;
      if (fl[k]) begin
        nv[k] = 1'b0; nw[k] = '0;
      end else if (held) begin
        nv[k] = mv[k]; nw[k] = mw[k];
      end else if (up_held) begin
        nv[k] = 1'b0; nw[k] = '0; bub = 1;
      end else if (k == 0) begin
        nv[k] = v; nw[k] = v ? w : '0;
      end else begin
        nv[k] = mv[k-1]; nw[k] = mw[k-1];
      end
    end
    for (int k = 0; k < int'(D); k++) begin
      mv[k] = nv[k];
      mw[k] = nw[k];
    end
    if (bub && mb < 65535) mb++;
    if (fhit && mf < 65535) mf++;
  endtask

  task automatic check_all(input string tag);
    logic [D-1:0]  ev;
    logic [DW-1:0] ew;
    for (int k = 0; k < int'(D); k++) begin
      ev[k] = mv[k];
      ew[k*W +: W] = mw[k];
    end
    chk({tag, ".valid"}, 64'(out_valid), 64'(ev));
    chk({tag, ".word"},  64'(out_word),  64'(ew));
`ifdef PIPE_CTRL_PERF_EN
    chk({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(mb));
    chk({tag, ".flush_cnt"},  64'(flush_cnt),  64'(mf));
`endif
  endtask

  // Drive one cycle of inputs, advance the model, and check just after the edge
  task automatic cycle(input string tag, input logic v, input logic [W-1:0] w,
                       input logic [D-1:0] st, input logic [D-1:0] fl);
    in_valid = v;
    in_word  = w;
    stall    = st;
    flush    = fl;
    model_step(v, w, st, fl);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [15:0] snap;
    rst = 1'b0;
    in_valid = 1'b0;
    in_word = '0;
    stall = '0;
    flush = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Flow: three words on consecutive cycles
    cycle("flow0", 1'b1, 12'h111, 3'b000, 3'b000);
    cycle("flow1", 1'b1, 12'h222, 3'b000, 3'b000);
    cycle("flow2", 1'b1, 12'h333, 3'b000, 3'b000);
    chk("flow.valid", 64'(out_valid), 64'(3'b111));
    chk("flow.s0", 64'(out_word[0  +: W]), 64'h333);
    chk("flow.s2", 64'(out_word[24 +: W]), 64'h111);

    // Stall boundary: stall[1] for two cycles creates bubbles on stage 2
    cycle("fillA", 1'b1, 12'h00C, 3'b000, 3'b000);
    cycle("fillB", 1'b1, 12'h00B, 3'b000, 3'b000);
    cycle("fillC", 1'b1, 12'h00A, 3'b000, 3'b000);
`ifdef PIPE_CTRL_PERF_EN
    snap = bubble_cnt;
`else
    snap = '0;
`endif
    cycle("stall1a", 1'b0, 12'h000, 3'b010, 3'b000);
    chk("stall1a.s2v", 64'(out_valid[2]), 64'd0);
    chk("stall1a.s1", 64'(out_word[12 +: W]), 64'h00B);
    cycle("stall1b", 1'b0, 12'h000, 3'b010, 3'b000);
    chk("stall1b.s2w", 64'(out_word[24 +: W]), 64'h000);
    chk("stall1b.s0", 64'(out_word[0 +: W]), 64'h00A);
`ifdef PIPE_CTRL_PERF_EN
    chk("stall1.bubbles", 64'(bubble_cnt - snap), 64'd2);
`endif
    cycle("resume", 1'b0, 12'h000, 3'b000, 3'b000);
    chk("resume.s2", 64'(out_word[24 +: W]), 64'h00B);

    // Full freeze: no bubbles anywhere
    cycle("load", 1'b1, 12'h5A5, 3'b000, 3'b000);
    cycle("freeze", 1'b1, 12'h777, 3'b111, 3'b000);

    // Flush with stall on stage 0: killed and then held as a bubble
    cycle("fstall0", 1'b1, 12'h777, 3'b001, 3'b001);
    chk("fstall0.s0", 64'({out_valid[0], out_word[0 +: W]}), 64'h0);
    cycle("fstall1", 1'b1, 12'h777, 3'b001, 3'b000);
    chk("fstall1.s0", 64'({out_valid[0], out_word[0 +: W]}), 64'h0);

    // Flush of an invalid stage changes nothing
    cycle("mk_inv", 1'b0, 12'h000, 3'b000, 3'b000);
    cycle("mk_inv2", 1'b0, 12'h000, 3'b011, 3'b000);
    cycle("finv", 1'b0, 12'h000, 3'b011, 3'b100);

    // Async reset mid-stream
    cycle("r0", 1'b1, 12'hABC, 3'b000, 3'b000);
    cycle("r1", 1'b1, 12'hDEF, 3'b000, 3'b000);
    cycle("r2", 1'b1, 12'h123, 3'b000, 3'b000);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b1;
    cycle("post_rst", 1'b1, 12'h7E7, 3'b000, 3'b000);
    chk("post_rst.s0", 64'({out_valid[0], out_word[0 +: W]}), 64'h17E7);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [D-1:0] st;
      logic [D-1:0] fl;
      st = ($urandom_range(0, 3) == 0) ? D'($urandom) : '0;
      fl = ($urandom_range(0, 5) == 0) ? D'($urandom) : '0;
      cycle("rand", 1'($urandom), W'($urandom), st, fl);
    end

`ifdef PIPE_CTRL_PERF_EN
    // Saturation of the bubble counter
    for (int i = 0; i < 65540; i++) begin
      cycle("sat", 1'b1, 12'h3C3, 3'b010, 3'b000);
    end
    chk("sat.bubble", 64'(bubble_cnt), 64'hFFFF);
    cycle("sat_hold", 1'b1, 12'h3C3, 3'b010, 3'b000);
    chk("sat_hold.bubble", 64'(bubble_cnt), 64'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
